// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file: selects the writeback value,
// commits it on the rising edge, and serves two decode read ports with same-cycle bypass.
module wb_regfile #(
    parameter int NREG = 32,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            startin,
    input  logic            regwrite,
    input  logic            jump,
    input  logic            memtoreg,
    input  logic [31:0]     aluResult,
    input  logic [31:0]     memReadData,
    input  logic [4:0]      regDstMux,
    input  logic [4:0]      rs,
    input  logic [4:0]      rt,
    output logic [31:0]     readData1,
    output logic [31:0]     readData2,
    output logic [31:0]     wbData,
    output logic            wbValid,
    output logic [CNTW-1:0] wbCount
);

    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    logic [31:0]     r_regs [NREG];
    logic [CNTW-1:0] r_count;
    logic [31:0]     w_wb_data;
    logic            w_wb_valid;

    // Writeback value select; jump carries the link address in aluResult
    always_comb begin
        w_wb_data = 32'd0;
        if (jump) begin
            w_wb_data = aluResult;
        end else if (memtoreg) begin
            w_wb_data = memReadData;
        end else begin
            w_wb_data = aluResult;
        end
    end

    assign w_wb_valid = startin & regwrite & (regDstMux != 5'd0);
    assign wbData     = w_wb_data;
    assign wbValid    = w_wb_valid;
    assign wbCount    = r_count;

    // Register array commit and committed-write counter, cleared by startin low
    always_ff @(posedge clk) begin
        if (!startin) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= 32'd0;
            end
            r_count <= {CNTW{1'b0}};
        end else if (w_wb_valid) begin
            r_regs[regDstMux] <= w_wb_data;
            r_count           <= r_count + CNT_ONE;
        end else begin
            r_count <= r_count;
        end
    end

    // Read port 1: zero register, then bypass, then array
    always_comb begin
        readData1 = 32'd0;
        if (rs == 5'd0) begin
            readData1 = 32'd0;
        end else if (w_wb_valid && (rs == regDstMux)) begin
            readData1 = w_wb_data;
        end else begin
            readData1 = r_regs[rs];
        end
    end

    // Read port 2: same priority as port 1
    always_comb begin
        readData2 = 32'd0;
        if (rt == 5'd0) begin
            readData2 = 32'd0;
        end else if (w_wb_valid && (rt == regDstMux)) begin
            readData2 = w_wb_data;
        end else begin
            readData2 = r_regs[rt];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; a second instance with CNTW=4
// shares the stimulus to exercise counter wrap.
module tb_wb_regfile;

    logic        clk;
    logic        startin;
    logic        regwrite;
    logic        jump;
    logic        memtoreg;
    logic [31:0] aluResult;
    logic [31:0] memReadData;
    logic [4:0]  regDstMux;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] readData1, readData2, wbData;
    logic        wbValid;
    logic [31:0] wbCount;
    logic [31:0] readData1_s4, readData2_s4, wbData_s4;
    logic        wbValid_s4;
    logic [3:0]  wbCount_s4;

    int checks = 0;
    int errors = 0;

    wb_regfile #(.NREG(32), .CNTW(32)) u_dut (
        .clk(clk), .startin(startin), .regwrite(regwrite), .jump(jump),
        .memtoreg(memtoreg), .aluResult(aluResult), .memReadData(memReadData),
        .regDstMux(regDstMux), .rs(rs), .rt(rt),
        .readData1(readData1), .readData2(readData2), .wbData(wbData),
        .wbValid(wbValid), .wbCount(wbCount)
    );

    wb_regfile #(.NREG(32), .CNTW(4)) u_dut4 (
        .clk(clk), .startin(startin), .regwrite(regwrite), .jump(jump),
        .memtoreg(memtoreg), .aluResult(aluResult), .memReadData(memReadData),
        .regDstMux(regDstMux), .rs(rs), .rt(rt),
        .readData1(readData1_s4), .readData2(readData2_s4), .wbData(wbData_s4),
        .wbValid(wbValid_s4), .wbCount(wbCount_s4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one edge, then settle inputs/outputs away from the edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        regwrite    = 1'b0;
        jump        = 1'b0;
        memtoreg    = 1'b0;
        aluResult   = 32'd0;
        memReadData = 32'd0;
        regDstMux   = 5'd0;
    endtask

    task automatic write_reg(input logic [4:0] dst, input logic [31:0] val);
        regwrite  = 1'b1;
        jump      = 1'b0;
        memtoreg  = 1'b0;
        aluResult = val;
        regDstMux = dst;
        tick();
        idle();
        #1;
    endtask

    task automatic test_reset();
        startin = 1'b1;
        write_reg(5'd5, 32'h0000_0055);
        write_reg(5'd31, 32'h3131_3131);
        rs = 5'd5; rt = 5'd31; #1;
        checks++;
        if (readData1 !== 32'h0000_0055 || readData2 !== 32'h3131_3131) begin
            errors++;
            $display("FAIL pre_reset_read: got %h/%h expected 00000055/31313131", readData1, readData2);
        end
        startin = 1'b0;
        regwrite = 1'b1; regDstMux = 5'd5; aluResult = 32'h77; #1;
        checks++;
        if (wbValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_wbvalid: got %b expected 0", wbValid);
        end
        tick();
        tick();
        idle();
        startin = 1'b1; #1;
        checks++;
        if (readData1 !== 32'd0 || readData2 !== 32'd0) begin
            errors++;
            $display("FAIL reset_read: got %h/%h expected 0/0", readData1, readData2);
        end
        checks++;
        if (wbCount !== 32'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", wbCount);
        end
    endtask

    task automatic test_select_commit();
        regwrite = 1'b1; memtoreg = 1'b1; jump = 1'b0;
        memReadData = 32'hDEAD_BEEF; aluResult = 32'h0000_1234; regDstMux = 5'd7; #1;
        checks++;
        if (wbData !== 32'hDEAD_BEEF || wbValid !== 1'b1) begin
            errors++;
            $display("FAIL select_mem: got %h/%b expected deadbeef/1", wbData, wbValid);
        end
        tick();
        memtoreg = 1'b0; jump = 1'b1; regDstMux = 5'd8; #1;
        checks++;
        if (wbData !== 32'h0000_1234) begin
            errors++;
            $display("FAIL select_jump: got %h expected 00001234", wbData);
        end
        tick();
        idle();
        jump = 1'b1; memtoreg = 1'b1; aluResult = 32'hCAFE_0001; memReadData = 32'hBAD0_0002; #1;
        checks++;
        if (wbData !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL jump_priority: got %h expected cafe0001", wbData);
        end
        idle();
        rs = 5'd7; rt = 5'd8; #1;
        checks++;
        if (readData1 !== 32'hDEAD_BEEF || readData2 !== 32'h0000_1234) begin
            errors++;
            $display("FAIL commit_read: got %h/%h expected deadbeef/00001234", readData1, readData2);
        end
        checks++;
        if (wbCount !== 32'd2) begin
            errors++;
            $display("FAIL commit_count: got %0d expected 2", wbCount);
        end
    endtask

    task automatic test_bypass();
        regwrite = 1'b1; regDstMux = 5'd3; aluResult = 32'hA5A5_A5A5;
        rs = 5'd3; rt = 5'd3; #1;
        checks++;
        if (readData1 !== 32'hA5A5_A5A5 || readData2 !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL bypass_same_cycle: got %h/%h expected a5a5a5a5", readData1, readData2);
        end
        tick();
        idle(); #1;
        checks++;
        if (readData1 !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL bypass_committed: got %h expected a5a5a5a5", readData1);
        end
        checks++;
        if (wbCount !== 32'd3) begin
            errors++;
            $display("FAIL bypass_count: got %0d expected 3", wbCount);
        end
    endtask

    task automatic test_back_to_back();
        regwrite = 1'b1; regDstMux = 5'd3; aluResult = 32'h0000_0001; rs = 5'd3; rt = 5'd2;
        tick();
        aluResult = 32'h0000_0002; #1;
        checks++;
        if (readData1 !== 32'h0000_0002) begin
            errors++;
            $display("FAIL b2b_bypass: got %h expected 00000002", readData1);
        end
        checks++;
        if (readData2 !== 32'd0) begin
            errors++;
            $display("FAIL b2b_other_port: got %h expected 0", readData2);
        end
        tick();
        idle(); #1;
        checks++;
        if (readData1 !== 32'h0000_0002 || wbCount !== 32'd5) begin
            errors++;
            $display("FAIL b2b_final: got %h/%0d expected 00000002/5", readData1, wbCount);
        end
    endtask

    task automatic test_reg_zero();
        regwrite = 1'b1; regDstMux = 5'd0; aluResult = 32'hFFFF_FFFF; rs = 5'd0; rt = 5'd0; #1;
        checks++;
        if (readData1 !== 32'd0 || readData2 !== 32'd0) begin
            errors++;
            $display("FAIL zero_read: got %h/%h expected 0/0", readData1, readData2);
        end
        checks++;
        if (wbValid !== 1'b0) begin
            errors++;
            $display("FAIL zero_wbvalid: got %b expected 0", wbValid);
        end
        tick();
        idle(); #1;
        checks++;
        if (wbCount !== 32'd5) begin
            errors++;
            $display("FAIL zero_count: got %0d expected 5", wbCount);
        end
    endtask

    task automatic test_reset_mid_write();
        write_reg(5'd4, 32'h0000_0011);
        rs = 5'd4; rt = 5'd4; #1;
        checks++;
        if (readData1 !== 32'h0000_0011 || wbCount !== 32'd6) begin
            errors++;
            $display("FAIL mid_pre: got %h/%0d expected 00000011/6", readData1, wbCount);
        end
        startin = 1'b0; regwrite = 1'b1; regDstMux = 5'd4; aluResult = 32'h0000_0022; #1;
        checks++;
        if (readData1 !== 32'h0000_0011 || readData2 !== 32'h0000_0011) begin
            errors++;
            $display("FAIL mid_no_bypass: got %h/%h expected 00000011", readData1, readData2);
        end
        checks++;
        if (wbData !== 32'h0000_0022 || wbValid !== 1'b0) begin
            errors++;
            $display("FAIL mid_wbdata: got %h/%b expected 00000022/0", wbData, wbValid);
        end
        tick();
        idle();
        startin = 1'b1; #1;
        checks++;
        if (readData1 !== 32'd0 || wbCount !== 32'd0) begin
            errors++;
            $display("FAIL mid_after: got %h/%0d expected 0/0", readData1, wbCount);
        end
    endtask

    task automatic test_counter_wrap();
        for (int i = 0; i < 17; i++) begin
            regwrite = 1'b1; regDstMux = 5'd9; aluResult = 32'(i + 1);
            tick();
        end
        idle();
        rs = 5'd9; rt = 5'd9; #1;
        checks++;
        if (wbCount_s4 !== 4'd1) begin
            errors++;
            $display("FAIL wrap_count4: got %0d expected 1", wbCount_s4);
        end
        checks++;
        if (wbCount !== 32'd17) begin
            errors++;
            $display("FAIL wrap_count32: got %0d expected 17", wbCount);
        end
        checks++;
        if (readData1_s4 !== 32'd17 || readData2_s4 !== 32'd17) begin
            errors++;
            $display("FAIL wrap_read4: got %h/%h expected 11/11", readData1_s4, readData2_s4);
        end
        checks++;
        if (wbValid_s4 !== 1'b0 || wbData_s4 !== 32'd0) begin
            errors++;
            $display("FAIL wrap_idle4: got %b/%h expected 0/0", wbValid_s4, wbData_s4);
        end
    endtask

    initial begin
        startin = 1'b0;
        rs = 5'd0;
        rt = 5'd0;
        idle();
        tick();
        tick();
        test_reset();
        test_select_commit();
        test_bypass();
        test_back_to_back();
        test_reg_zero();
        test_reset_mid_write();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
